// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage and the data memory.
// Carries one request (address, lanes, store data) and its acknowledge.
`ifndef MEM_ACCESS_DEFINES
`define MEM_ACCESS_DEFINES
`define RegBus      32
`define RegAddrBus  5
`define AluOpBus    8
`define InstAddrBus 32
`endif

interface mem_access_if;
  logic                dmem_req_o;
  logic                dmem_we_o;
  logic [`RegBus-1:0]  dmem_addr_o;
  logic [3:0]          dmem_sel_o;
  logic [`RegBus-1:0]  dmem_wdata_o;
  logic [`RegBus-1:0]  dmem_rdata_i;
  logic                dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_sel_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_sel_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage: issues one data-memory access at a time and stalls the pipeline until it completes.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of issuing them.
`ifndef MEM_ACCESS_DEFINES
`define MEM_ACCESS_DEFINES
`define RegBus      32
`define RegAddrBus  5
`define AluOpBus    8
`define InstAddrBus 32
`endif

module mem_access (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`RegAddrBus-1:0]   waddr_i,
  input  logic [`RegBus-1:0]       wdata_i,
  input  logic                     we_i,
  input  logic [`AluOpBus-1:0]     aluop_i,
  input  logic [`InstAddrBus-1:0]  mem_addr_i,
  input  logic [`RegBus-1:0]       reg1_i,
  output logic [`RegAddrBus-1:0]   waddr_o,
  output logic [`RegBus-1:0]       wdata_o,
  output logic                     we_o,
  mem_access_if.master             dmem,
  output logic                     stallreq_o,
  output logic                     misalign_o
);

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q;
  logic [7:0]  op_q;
  logic        store_q, req_q;

  logic        is_load, is_store, misaligned, issue;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d, load_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request decode from the current EX/MEM contents.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sel_d    = 4'b0000;
    wdata_d  = reg1_i;
    case (aluop_i)
      OpLb, OpLbu: begin
        is_load = 1'b1;
        sel_d   = 4'b0001 << mem_addr_i[1:0];
      end
      OpLh, OpLhu: begin
        is_load = 1'b1;
        sel_d   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      OpLw: begin
        is_load = 1'b1;
        sel_d   = 4'b1111;
      end
      OpSb: begin
        is_store = 1'b1;
        sel_d    = 4'b0001 << mem_addr_i[1:0];
        wdata_d  = {4{reg1_i[7:0]}};
      end
      OpSh: begin
        is_store = 1'b1;
        sel_d    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {2{reg1_i[15:0]}};
      end
      OpSw: begin
        is_store = 1'b1;
        sel_d    = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic is_half, is_word;
  assign is_half    = (aluop_i == OpLh) || (aluop_i == OpLhu) || (aluop_i == OpSh);
  assign is_word    = (aluop_i == OpLw) || (aluop_i == OpSw);
  assign misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = !rst && (state_q == StIdle) && misaligned;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign issue = (state_q == StIdle) && (is_load || is_store) && !misaligned;

  // Extract and extend the addressed byte/half of the returned word.
  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    ld_byte = dmem.dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem.dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata_i[23:16];
      default: ld_byte = dmem.dmem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
    case (op_q)
      OpLb:    load_fmt = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   load_fmt = {24'b0, ld_byte};
      OpLh:    load_fmt = {{16{ld_half[15]}}, ld_half};
      OpLhu:   load_fmt = {16'b0, ld_half};
      default: load_fmt = dmem.dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      op_q    <= '0;
      store_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            addr_q  <= mem_addr_i;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            op_q    <= aluop_i;
            store_q <= is_store;
            req_q   <= 1'b1;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (dmem.dmem_ack_i) begin
            rdata_q <= load_fmt;
            req_q   <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = store_q;
  assign dmem.dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_sel_o   = sel_q;
  assign dmem.dmem_wdata_o = wdata_q;

  always_comb begin
    waddr_o    = '0;
    wdata_o    = '0;
    we_o       = 1'b0;
    stallreq_o = 1'b0;
    if (!rst) begin
      waddr_o = waddr_i;
      wdata_o = wdata_i;
      unique case (state_q)
        StIdle: begin
          if (is_load || is_store) stallreq_o = !misaligned;
          else                     we_o       = we_i;
        end
        StBusy: stallreq_o = 1'b1;
        StDone: begin
          if (!store_q) begin
            wdata_o = rdata_q;
            we_o    = we_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a behavioural memory slave acknowledges requests and a
// scoreboard of expected writebacks is checked in each DONE cycle.
module tb_mem_access;

  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpAdd = 8'b0010_0000;
  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr_i, waddr_o;
  logic [31:0] wdata_i, wdata_o, mem_addr_i, reg1_i;
  logic        we_i, we_o, stallreq_o, misalign_o;
  logic [7:0]  aluop_i;

  mem_access_if bus ();

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .we_i       (we_i),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg1_i     (reg1_i),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .we_o       (we_o),
    .dmem       (bus),
    .stallreq_o (stallreq_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    bit          chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int          stalls;
  logic [3:0]  sel;
  logic [31:0] addr, wd;
  logic        dwe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rt,
                       input logic [4:0] wa, input logic [31:0] wdat, input logic wen);
    aluop_i    = op;
    mem_addr_i = a;
    reg1_i     = rt;
    waddr_i    = wa;
    wdata_i    = wdat;
    we_i       = wen;
  endtask

  task automatic push(input logic [4:0] wa, input logic [31:0] wdat, input logic wen,
                      input bit chk_data);
    exp_t e;
    e.waddr = wa; e.wdata = wdat; e.we = wen; e.chk_data = chk_data;
    sb_q.push_back(e);
  endtask

  // Entered at posedge+1 of the IDLE cycle holding a memory op; returns at posedge+1 after DONE.
  task automatic access(input string tag, input int ack_at, input logic [31:0] rdata,
                        output int n_stall, output logic [3:0] o_sel,
                        output logic [31:0] o_addr, output logic [31:0] o_wd, output logic o_we);
    int   busy_n;
    bit   done;
    exp_t e;
    n_stall = 0; busy_n = 0; done = 0;
    o_sel = '0; o_addr = '0; o_wd = '0; o_we = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!stallreq_o) begin
        done = 1;
      end else begin
        n_stall++;
        check({tag, " we_o while stalled"}, {31'b0, we_o}, 32'd0);
        if (bus.dmem_req_o) begin
          busy_n++;
          if (busy_n == 1) begin
            o_sel = bus.dmem_sel_o; o_addr = bus.dmem_addr_o;
            o_wd = bus.dmem_wdata_o; o_we = bus.dmem_we_o;
          end else begin
            check({tag, " addr held"}, bus.dmem_addr_o, o_addr);
          end
          if (busy_n == ack_at) begin
            bus.dmem_ack_i   = 1'b1;
            bus.dmem_rdata_i = rdata;
          end
        end
        @(posedge clk);
        #1;
        bus.dmem_ack_i = 1'b0;
      end
    end
    check({tag, " reached DONE"}, {31'b0, done}, 32'd1);
    if (done) begin
      check({tag, " req low in DONE"}, {31'b0, bus.dmem_req_o}, 32'd0);
      check({tag, " scoreboard entry"}, {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({tag, " waddr_o"}, {27'b0, waddr_o}, {27'b0, e.waddr});
        check({tag, " we_o"}, {31'b0, we_o}, {31'b0, e.we});
        if (e.chk_data) check({tag, " wdata_o"}, wdata_o, e.wdata);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.dmem_ack_i = 1'b0;
    bus.dmem_rdata_i = '0;
    drive(OpAdd, 32'h0, 32'h0, 5'd3, 32'h12, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst waddr_o", {27'b0, waddr_o}, 32'd0);
    check("rst wdata_o", wdata_o, 32'd0);
    check("rst we_o", {31'b0, we_o}, 32'd0);
    check("rst stallreq_o", {31'b0, stallreq_o}, 32'd0);
    check("rst dmem_req_o", {31'b0, bus.dmem_req_o}, 32'd0);
    check("rst misalign_o", {31'b0, misalign_o}, 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("add waddr_o", {27'b0, waddr_o}, 32'd3);
    check("add wdata_o", wdata_o, 32'h12);
    check("add we_o", {31'b0, we_o}, 32'd1);
    check("add stallreq_o", {31'b0, stallreq_o}, 32'd0);
    check("add dmem_req_o", {31'b0, bus.dmem_req_o}, 32'd0);

    @(posedge clk); #1;
    drive(OpLb, 32'h1003, 32'h0, 5'd5, 32'hDEAD, 1'b1);
    push(5'd5, 32'hFFFF_FF80, 1'b1, 1'b1);
    access("lb", 3, 32'h80FF_FFFF, stalls, sel, addr, wd, dwe);
    check("lb stalls", stalls, 32'd4);
    check("lb sel", {28'b0, sel}, 32'b1000);
    check("lb addr", addr, 32'h1000);
    check("lb dmem_we", {31'b0, dwe}, 32'd0);

    drive(OpSh, 32'h2002, 32'hABCD_1234, 5'd7, 32'h55, 1'b1);
    push(5'd7, 32'h0, 1'b0, 1'b0);
    access("sh", 1, 32'h0, stalls, sel, addr, wd, dwe);
    check("sh dmem_we", {31'b0, dwe}, 32'd1);
    check("sh sel", {28'b0, sel}, 32'b1100);
    check("sh wdata", wd, 32'h1234_1234);
    check("sh addr", addr, 32'h2000);
    check("sh stalls", stalls, 32'd2);

    drive(OpLhu, 32'h0, 32'h0, 5'd9, 32'h0, 1'b1);
    push(5'd9, 32'h0000_F00D, 1'b1, 1'b1);
    access("lhu", 1, 32'h0000_F00D, stalls, sel, addr, wd, dwe);
    check("lhu stalls", stalls, 32'd2);
    check("lhu sel", {28'b0, sel}, 32'b0011);

    drive(OpLw, 32'h100, 32'h0, 5'd10, 32'h0, 1'b1);
    push(5'd10, 32'h1111_1111, 1'b1, 1'b1);
    access("lw0", 2, 32'h1111_1111, stalls, sel, addr, wd, dwe);
    check("lw0 stalls", stalls, 32'd3);
    check("lw0 addr", addr, 32'h100);
    drive(OpLw, 32'h104, 32'h0, 5'd11, 32'h0, 1'b1);
    push(5'd11, 32'h2222_2222, 1'b1, 1'b1);
    access("lw1", 1, 32'h2222_2222, stalls, sel, addr, wd, dwe);
    check("lw1 addr", addr, 32'h104);
    check("lw1 sel", {28'b0, sel}, 32'b1111);

    drive(OpLh, 32'h302, 32'h0, 5'd12, 32'h0, 1'b1);
    push(5'd12, 32'hFFFF_8001, 1'b1, 1'b1);
    access("lh", 1, 32'h8001_7777, stalls, sel, addr, wd, dwe);
    check("lh sel", {28'b0, sel}, 32'b1100);

    drive(OpSb, 32'h401, 32'h0000_005A, 5'd13, 32'h0, 1'b1);
    push(5'd13, 32'h0, 1'b0, 1'b0);
    access("sb", 2, 32'h0, stalls, sel, addr, wd, dwe);
    check("sb sel", {28'b0, sel}, 32'b0010);
    check("sb wdata", wd, 32'h5A5A_5A5A);

    drive(OpLbu, 32'h502, 32'h0, 5'd14, 32'h0, 1'b1);
    push(5'd14, 32'h0000_00AB, 1'b1, 1'b1);
    access("lbu", 1, 32'h00AB_0000, stalls, sel, addr, wd, dwe);
    check("lbu sel", {28'b0, sel}, 32'b0100);

    drive(OpLw, 32'h5, 32'h0, 5'd15, 32'h0, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    check("mis misalign_o", {31'b0, misalign_o}, 32'd1);
    check("mis stallreq_o", {31'b0, stallreq_o}, 32'd0);
    check("mis we_o", {31'b0, we_o}, 32'd0);
    @(posedge clk); #1;
    drive(OpNop, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("mis no request", {31'b0, bus.dmem_req_o}, 32'd0);
    @(posedge clk); #1;
`else
    @(negedge clk);
    check("lw5 misalign_o", {31'b0, misalign_o}, 32'd0);
    @(posedge clk); #1;
    bus.dmem_ack_i = 1'b0;
    push(5'd15, 32'h3333_3333, 1'b1, 1'b1);
    // State is already BUSY here; the access task finds the request on its first cycle.
    access("lw5", 1, 32'h3333_3333, stalls, sel, addr, wd, dwe);
    check("lw5 addr", addr, 32'h4);
    check("lw5 sel", {28'b0, sel}, 32'b1111);
`endif

    drive(OpLw, 32'h40, 32'h0, 5'd4, 32'h0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbusy req before", {31'b0, bus.dmem_req_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(OpNop, 32'h0, 32'h0, 5'd2, 32'h77, 1'b1);
    bus.dmem_ack_i = 1'b1;
    bus.dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rstbusy req after", {31'b0, bus.dmem_req_o}, 32'd0);
    check("rstbusy stallreq_o", {31'b0, stallreq_o}, 32'd0);
    check("rstbusy wdata_o", wdata_o, 32'h77);
    @(posedge clk); #1;
    bus.dmem_ack_i = 1'b0;
    @(negedge clk);
    check("late ack req", {31'b0, bus.dmem_req_o}, 32'd0);
    check("late ack stallreq_o", {31'b0, stallreq_o}, 32'd0);
    check("late ack wdata_o", wdata_o, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
